// File: rtl/psec6_trig_pkg.sv
// Shared types and limits for the trigger synchronizer.
// Edge polarity encoding and minimum legal chain/filter depths.
package psec6_trig_pkg;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_sel_e;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MIN_FILTER_LEN  = 1;

endpackage

// File: rtl/trigger_sync_channel.sv
// One trigger channel: sync chain, glitch filter, edge select,
// holdoff counter and sticky missed-trigger flag.
module trigger_sync_channel
  import psec6_trig_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 1,
  parameter int HOLDOFF_W   = 8
) (
  input  logic                 FCLK,
  input  logic                 RST,
  input  logic                 trig_async,
  input  logic                 ch_enable,
  input  logic                 edge_sel,
  input  logic [HOLDOFF_W-1:0] holdoff_cycles,
  input  logic                 clear_missed,
  output logic                 trig_level,
  output logic                 trig_pulse,
  output logic                 trig_busy,
  output logic                 trig_missed,
  output logic                 accept
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
  end
  if (FILTER_LEN < MIN_FILTER_LEN) begin : g_bad_filt
    $error("FILTER_LEN must be >= %0d", MIN_FILTER_LEN);
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic [HOLDOFF_W-1:0]   hold_q;
  logic [HOLDOFF_W-1:0]   hold_d;
  logic                   s;
  logic                   commit;
  logic                   sel_edge;
  logic                   miss_set;
  logic                   is_rise;

  assign s        = sync_q[SYNC_STAGES-1];
  assign is_rise  = edge_sel_e'(edge_sel) == EDGE_RISE;
  assign commit   = (s != trig_level) &&
                    (cnt_q == CW'(FILTER_LEN - 1));
  assign sel_edge = commit && (s == is_rise);
  assign accept   = sel_edge && ch_enable &&
                    (hold_q == '0);
  assign miss_set = sel_edge && ch_enable &&
                    (hold_q != '0);

  // Disable wins so a re-enabled channel starts with no dead time.
  always_comb begin
    hold_d = hold_q;
    if (!ch_enable) begin
      hold_d = '0;
    end else if (accept) begin
      hold_d = holdoff_cycles;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLDOFF_W'(1);
    end
  end

  always_ff @(posedge FCLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trig_async};
    end
  end

  always_ff @(posedge FCLK or posedge RST) begin
    if (RST) begin
      cnt_q      <= '0;
      trig_level <= 1'b0;
    end else if (s == trig_level) begin
      cnt_q <= '0;
    end else if (commit) begin
      cnt_q      <= '0;
      trig_level <= s;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge FCLK or posedge RST) begin
    if (RST) begin
      hold_q      <= '0;
      trig_busy   <= 1'b0;
      trig_pulse  <= 1'b0;
      trig_missed <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      trig_busy  <= hold_d != '0;
      trig_pulse <= accept;
      // A miss in the same cycle as a clear keeps the flag set.
      if (miss_set) begin
        trig_missed <= 1'b1;
      end else if (clear_missed) begin
        trig_missed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_trigger_synchronizer.sv
// Multi-channel async trigger synchronizer into the FCLK domain.
// NCH independent channels plus a registered any-trigger strobe.
module multi_trigger_synchronizer
  import psec6_trig_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 1,
  parameter int HOLDOFF_W   = 8
) (
  input  logic                 FCLK,
  input  logic                 RST,
  input  logic [NCH-1:0]       trig_async,
  input  logic [NCH-1:0]       ch_enable,
  input  logic [NCH-1:0]       edge_sel,
  input  logic [HOLDOFF_W-1:0] holdoff_cycles,
  input  logic                 clear_missed,
  output logic [NCH-1:0]       trig_level,
  output logic [NCH-1:0]       trig_pulse,
  output logic                 trig_any,
  output logic [NCH-1:0]       trig_busy,
  output logic [NCH-1:0]       trig_missed
);

  logic [NCH-1:0] accept;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    trigger_sync_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .HOLDOFF_W   (HOLDOFF_W)
    ) u_ch (
      .FCLK           (FCLK),
      .RST            (RST),
      .trig_async     (trig_async[i]),
      .ch_enable      (ch_enable[i]),
      .edge_sel       (edge_sel[i]),
      .holdoff_cycles (holdoff_cycles),
      .clear_missed   (clear_missed),
      .trig_level     (trig_level[i]),
      .trig_pulse     (trig_pulse[i]),
      .trig_busy      (trig_busy[i]),
      .trig_missed    (trig_missed[i]),
      .accept         (accept[i])
    );
  end

  // Built from the pre-register accepts so it lines up with trig_pulse.
  always_ff @(posedge FCLK or posedge RST) begin
    if (RST) begin
      trig_any <= 1'b0;
    end else begin
      trig_any <= |accept;
    end
  end

endmodule

// File: tb/tb_multi_trigger_synchronizer.sv
// Scoreboard bench: FILTER_LEN=1 and FILTER_LEN=4 instances side by side,
// a queue-based reference model, and directed plus random stimulus.
module tb_multi_trigger_synchronizer;

  localparam int NCH = 4;
  localparam int S   = 2;

  typedef struct packed {
    logic [NCH-1:0] lvl;
    logic [NCH-1:0] pulse;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] missed;
    logic           any;
  } obs_t;

  logic           FCLK = 1'b0;
  logic           RST = 1'b0;
  logic [NCH-1:0] trig_async = '0;
  logic [NCH-1:0] ch_enable = '0;
  logic [NCH-1:0] edge_sel = '0;
  logic [7:0]     holdoff_cycles = '0;
  logic           clear_missed = 1'b0;

  logic [NCH-1:0] lvl [2];
  logic [NCH-1:0] pulse [2];
  logic [NCH-1:0] busy [2];
  logic [NCH-1:0] missed [2];
  logic           any [2];

  multi_trigger_synchronizer #(
    .NCH(NCH), .SYNC_STAGES(S), .FILTER_LEN(1), .HOLDOFF_W(8)
  ) u_f1 (
    .FCLK(FCLK), .RST(RST), .trig_async(trig_async),
    .ch_enable(ch_enable), .edge_sel(edge_sel),
    .holdoff_cycles(holdoff_cycles), .clear_missed(clear_missed),
    .trig_level(lvl[0]), .trig_pulse(pulse[0]), .trig_any(any[0]),
    .trig_busy(busy[0]), .trig_missed(missed[0])
  );

  multi_trigger_synchronizer #(
    .NCH(NCH), .SYNC_STAGES(S), .FILTER_LEN(4), .HOLDOFF_W(8)
  ) u_f4 (
    .FCLK(FCLK), .RST(RST), .trig_async(trig_async),
    .ch_enable(ch_enable), .edge_sel(edge_sel),
    .holdoff_cycles(holdoff_cycles), .clear_missed(clear_missed),
    .trig_level(lvl[1]), .trig_pulse(pulse[1]), .trig_any(any[1]),
    .trig_busy(busy[1]), .trig_missed(missed[1])
  );

  always #5 FCLK = ~FCLK;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit   pipe [NCH][$];
  bit   mlvl [2][NCH];
  int   run  [2][NCH];
  int   hend [2][NCH];
  bit   mmis [2][NCH];
  int   cyc = 0;
  obs_t expq [2][$];

  function automatic int flen(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic obs_t dut_obs(input int k);
    obs_t o;
    o.lvl    = lvl[k];
    o.pulse  = pulse[k];
    o.busy   = busy[k];
    o.missed = missed[k];
    o.any    = any[k];
    return o;
  endfunction

  task automatic check(input string name, input int got, input int exp_v);
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp_v);
    end
  endtask

  // Predicts the outputs after the next rising edge from the current inputs.
  task automatic model_edge();
    obs_t e [2];
    cyc++;
    e[0] = '0;
    e[1] = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      bit s;
      s = 1'b0;
      if (RST) begin
        pipe[ch] = {};
        for (int i = 0; i < S; i++) pipe[ch].push_back(1'b0);
      end else begin
        s = pipe[ch].pop_front();
        pipe[ch].push_back(trig_async[ch]);
      end
      for (int k = 0; k < 2; k++) begin
        bit sel;
        bit acc;
        bit set;
        sel = 0;
        acc = 0;
        set = 0;
        if (RST) begin
          mlvl[k][ch] = 0;
          run[k][ch]  = 0;
          hend[k][ch] = cyc;
          mmis[k][ch] = 0;
        end else begin
          if (s != mlvl[k][ch]) begin
            run[k][ch]++;
            if (run[k][ch] == flen(k)) begin
              mlvl[k][ch] = s;
              run[k][ch]  = 0;
              sel = (s == !edge_sel[ch]);
            end
          end else begin
            run[k][ch] = 0;
          end
          if (!ch_enable[ch]) begin
            hend[k][ch] = cyc;
          end else if (sel) begin
            if (cyc > hend[k][ch]) begin
              acc = 1;
              hend[k][ch] = cyc + int'(holdoff_cycles);
            end else begin
              set = 1;
            end
          end
          if (set) mmis[k][ch] = 1;
          else if (clear_missed) mmis[k][ch] = 0;
          e[k].lvl[ch]    = mlvl[k][ch];
          e[k].pulse[ch]  = acc;
          e[k].busy[ch]   = hend[k][ch] > cyc;
          e[k].missed[ch] = mmis[k][ch];
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      e[k].any = |e[k].pulse;
      expq[k].push_back(e[k]);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge FCLK);
    #2;
  endtask

  // Monitor: pops one prediction per instance per edge.
  initial begin
    int n;
    n = 0;
    forever begin
      @(posedge FCLK);
      #1;
      n++;
      for (int k = 0; k < 2; k++) begin
        if (expq[k].size() > 0) begin
          obs_t ev;
          obs_t gv;
          ev = expq[k].pop_front();
          gv = dut_obs(k);
          tests++;
          if (gv !== ev) begin
            fails++;
            $display("FAIL sb u%0d edge%0d got=%h exp=%h", k, n, gv, ev);
          end
        end
      end
    end
  end

  initial begin
    int np;
    int nb;
    int idx;
    int left [NCH];
    for (int ch = 0; ch < NCH; ch++) begin
      for (int i = 0; i < S; i++) pipe[ch].push_back(1'b0);
      left[ch] = 1;
    end
    #1 RST = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) check("rst_init", int'(dut_obs(k)), 0);
    ch_enable = '1;
    repeat (3) tick();
    RST = 1'b0;
    repeat (3) tick();

    // ch0 rise, S=2 F=1: level and pulse after edge 3, pulse one cycle
    trig_async[0] = 1'b1;
    repeat (3) tick();
    check("lat_pulse", int'(pulse[0][0]), 1);
    check("lat_any", int'(any[0]), 1);
    check("lat_lvl", int'(lvl[0][0]), 1);
    tick();
    check("pulse_1cyc", int'(pulse[0][0]), 0);
    trig_async[0] = 1'b0;
    repeat (4) tick();

    // F=4: 3-cycle glitch is filtered, 4-cycle high pulses after edge 6
    np = 0;
    for (int i = 0; i < 12; i++) begin
      trig_async[1] = (i < 3);
      tick();
      np += int'(pulse[1][1] | lvl[1][1]);
    end
    check("glitch_f4", np, 0);
    idx = -1;
    np = 0;
    for (int i = 0; i < 12; i++) begin
      trig_async[1] = (i < 4);
      tick();
      if (pulse[1][1]) begin
        np++;
        if (idx < 0) idx = i;
      end
    end
    check("f4_lat", idx, 5);
    check("f4_cnt", np, 1);

    // holdoff=5 on ch2, second rise 3 cycles later is missed
    holdoff_cycles = 8'd5;
    np = 0;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      trig_async[2] = (i == 0 || i == 3);
      tick();
      np += int'(pulse[0][2]);
      nb += int'(busy[0][2]);
    end
    check("ho_pulses", np, 1);
    check("ho_busy", nb, 5);
    check("ho_missed", int'(missed[0][2]), 1);
    for (int i = 0; i < 12; i++) begin
      trig_async[2] = (i == 0 || i == 3);
      clear_missed  = (i == 0 || i == 5);
      tick();
      if (i == 0) check("clr_missed", int'(missed[0][2]), 0);
      if (i == 5) check("clr_vs_set", int'(missed[0][2]), 1);
    end
    clear_missed = 1'b0;

    // falling-edge select on ch3
    edge_sel[3] = 1'b1;
    idx = -1;
    np = 0;
    for (int i = 0; i < 10; i++) begin
      trig_async[3] = (i < 4);
      tick();
      if (pulse[0][3]) begin
        np++;
        if (idx < 0) idx = i;
      end
    end
    check("fall_lat", idx, 6);
    check("fall_cnt", np, 1);

    // disabled ch0 tracks level silently; re-enable while high is silent
    ch_enable[0] = 1'b0;
    np = 0;
    for (int i = 0; i < 14; i++) begin
      trig_async[0] = (i < 4 || i >= 8);
      tick();
      np += int'(pulse[0][0]) + int'(pulse[1][0]);
    end
    ch_enable[0] = 1'b1;
    repeat (6) begin
      tick();
      np += int'(pulse[0][0]) + int'(pulse[1][0]);
    end
    check("dis_nopulse", np, 0);
    check("dis_lvl", int'(lvl[0][0]), 1);
    check("dis_nomiss", int'(missed[0][0] | missed[1][0]), 0);

    // reset mid-holdoff with the input held high
    holdoff_cycles = 8'd20;
    trig_async[0] = 1'b0;
    repeat (8) tick();
    trig_async[0] = 1'b1;
    repeat (4) tick();
    check("pre_rst_busy", int'(busy[0][0]), 1);
    RST = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) check("rst_async", int'(dut_obs(k)), 0);
    tick();
    check("rst_hold", int'(dut_obs(0)), 0);
    RST = 1'b0;
    idx = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pulse[0][0] && idx < 0) idx = i;
    end
    check("post_rst_lat", idx, 2);

    // random phases
    for (int p = 0; p < 4; p++) begin
      holdoff_cycles = 8'($urandom_range(0, 6));
      edge_sel  = NCH'($urandom);
      ch_enable = '1;
      for (int c = 0; c < 300; c++) begin
        for (int ch = 0; ch < NCH; ch++) begin
          left[ch]--;
          if (left[ch] <= 0) begin
            trig_async[ch] = ~trig_async[ch];
            left[ch] = $urandom_range(1, 7);
          end
        end
        if ($urandom_range(0, 40) == 0) begin
          idx = $urandom_range(0, NCH - 1);
          ch_enable[idx] = ~ch_enable[idx];
        end
        clear_missed = ($urandom_range(0, 15) == 0);
        RST = (p == 2 && c == 150);
        tick();
      end
      RST = 1'b0;
      clear_missed = 1'b0;
    end

    check("q0_drained", expq[0].size(), 0);
    check("q1_drained", expq[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
